// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the MIPS instruction fetch stage.
// Contents: FSM state type, instruction field positions, default reset PC,
// and a word-alignment helper used for every redirect target.
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StValid = 2'd2,
        StDrop  = 2'd3
    } fetch_state_e;

    localparam int unsigned OP_MSB   = 31;
    localparam int unsigned OP_LSB   = 26;
    localparam int unsigned JIDX_MSB = 25;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mips_fetch_unit_if.sv
// Instruction-memory read port of the fetch stage.
//   imem_req   : read request, held until imem_ack
//   imem_addr  : word address, stable while imem_req is high
//   imem_ack   : read data valid, completes the request
//   imem_rdata : instruction word returned with imem_ack
// master = fetch unit, slave = instruction memory.
interface mips_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_pc_sel.sv
// Next-PC selection for the fetch stage (purely combinational).
//   i_pc            : current PC
//   i_jidx          : instruction index field of the presented instruction
//   i_branch_target : branch PC from execute (low bits ignored)
//   i_redir_pc      : saved branch target awaiting a dropped fetch
//   i_sel_*         : select controls; branch > jump > redirect > increment
//   o_next_pc       : selected PC, i_pc when nothing is selected
module fetch_pc_sel
    import mips_fetch_pkg::*;
(
    input  logic [31:0]         i_pc,
    input  logic [JIDX_MSB:0]   i_jidx,
    input  logic [31:0]         i_branch_target,
    input  logic [31:0]         i_redir_pc,
    input  logic                i_sel_branch,
    input  logic                i_sel_jump,
    input  logic                i_sel_redir,
    input  logic                i_sel_inc,
    output logic [31:0]         o_next_pc
);

    always_comb begin
        o_next_pc = i_pc;
        if (i_sel_branch) begin
            o_next_pc = word_align(i_branch_target);
        end else if (i_sel_jump) begin
            // Jump region is taken from the already-incremented PC.
            o_next_pc = {i_pc[31:28], i_jidx, 2'b00};
        end else if (i_sel_redir) begin
            o_next_pc = i_redir_pc;
        end else if (i_sel_inc) begin
            o_next_pc = i_pc + 32'd4;
        end
    end

endmodule

// File: rtl/mips_fetch_unit.sv
// MIPS instruction fetch stage.
//   clk, rst_n     : clock, asynchronous active-low reset
//   imem           : instruction-memory read port (master side)
//   stall          : hold the presented instruction
//   jump           : decoder jump for the presented instruction
//   branch_taken   : taken branch from execute (older instruction)
//   branch_target  : branch PC, low bits ignored
//   instr          : instruction register; op / funct are its fields
//   instr_valid    : instr holds a live instruction
//   pc_plus4       : PC+4 of the presented instruction (jal link)
module mips_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                clk,
    input  logic                rst_n,
    mips_fetch_unit_if.master   imem,
    input  logic                stall,
    input  logic                jump,
    input  logic                branch_taken,
    input  logic [31:0]         branch_target,
    output logic [31:0]         instr,
    output logic [5:0]          op,
    output logic [5:0]          funct,
    output logic                instr_valid,
    output logic [31:0]         pc_plus4
);

    fetch_state_e r_state;
    fetch_state_e w_next_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_redir_pc;
    logic [31:0]  r_instr;
    logic         r_instr_valid;

    logic         w_sel_branch;
    logic         w_sel_jump;
    logic         w_sel_redir;
    logic         w_sel_inc;
    logic         w_instr_load;
    logic         w_valid_clr;
    logic         w_redir_load;
    logic [31:0]  w_next_pc;

    always_comb begin
        w_next_state = r_state;
        w_sel_branch = 1'b0;
        w_sel_jump   = 1'b0;
        w_sel_redir  = 1'b0;
        w_sel_inc    = 1'b0;
        w_instr_load = 1'b0;
        w_valid_clr  = 1'b0;
        w_redir_load = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_next_state = StFetch;
            end
            StFetch: begin
                if (branch_taken) begin
                    if (imem.imem_ack) begin
                        // Returned word is on the wrong path: refetch at once.
                        w_sel_branch = 1'b1;
                    end else begin
                        // Request must complete at its old address first.
                        w_redir_load = 1'b1;
                        w_next_state = StDrop;
                    end
                end else if (imem.imem_ack) begin
                    w_sel_inc    = 1'b1;
                    w_instr_load = 1'b1;
                    w_next_state = StValid;
                end
            end
            StValid: begin
                if (branch_taken) begin
                    w_sel_branch = 1'b1;
                    w_valid_clr  = 1'b1;
                    w_next_state = StFetch;
                end else if (jump) begin
                    w_sel_jump   = 1'b1;
                    w_valid_clr  = 1'b1;
                    w_next_state = StFetch;
                end else if (!stall) begin
                    w_valid_clr  = 1'b1;
                    w_next_state = StFetch;
                end
            end
            StDrop: begin
                if (branch_taken) begin
                    w_redir_load = 1'b1;
                end
                if (imem.imem_ack) begin
                    // A branch arriving with the ack is the newest target.
                    w_sel_branch = branch_taken;
                    w_sel_redir  = !branch_taken;
                    w_next_state = StFetch;
                end
            end
            default: begin
                w_next_state = StIdle;
            end
        endcase
    end

    fetch_pc_sel u_pc_sel (
        .i_pc            (r_pc),
        .i_jidx          (r_instr[JIDX_MSB:0]),
        .i_branch_target (branch_target),
        .i_redir_pc      (r_redir_pc),
        .i_sel_branch    (w_sel_branch),
        .i_sel_jump      (w_sel_jump),
        .i_sel_redir     (w_sel_redir),
        .i_sel_inc       (w_sel_inc),
        .o_next_pc       (w_next_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_pc          <= RESET_PC;
            r_redir_pc    <= 32'h0;
            r_instr       <= 32'h0;
            r_instr_valid <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
            if (w_redir_load) begin
                r_redir_pc <= word_align(branch_target);
            end
            if (w_instr_load) begin
                r_instr       <= imem.imem_rdata;
                r_instr_valid <= 1'b1;
            end else if (w_valid_clr) begin
                r_instr_valid <= 1'b0;
            end
        end
    end

    // All outputs come from registered state only.
    assign imem.imem_req  = (r_state == StFetch) || (r_state == StDrop);
    assign imem.imem_addr = r_pc;
    assign pc_plus4       = r_pc;
    assign instr          = r_instr;
    assign op             = r_instr[OP_MSB:OP_LSB];
    assign funct          = r_instr[5:0];
    assign instr_valid    = r_instr_valid;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Self-checking bench for mips_fetch_unit: a directed vector table, a
// mid-request reset sequence, and a randomized run against a reference model.
module tb_mips_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        jump;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        instr_valid;
    logic [31:0] pc_plus4;

    int n_checks;
    int n_errors;

    mips_fetch_unit_if u_if ();

    mips_fetch_unit #(
        .RESET_PC (32'h0000_0000)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem          (u_if.master),
        .stall         (stall),
        .jump          (jump),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instr         (instr),
        .op            (op),
        .funct         (funct),
        .instr_valid   (instr_valid),
        .pc_plus4      (pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        jump;
        logic        bt;
        logic [31:0] tgt;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic j, input logic b,
                                input logic [31:0] t, input logic a, input logic [31:0] d,
                                input logic er, input logic [31:0] ea, input logic ev,
                                input logic [31:0] ei);
        vec_t v;
        v.stall = s; v.jump = j; v.bt = b; v.tgt = t; v.ack = a; v.rdata = d;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_instr = ei;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic j, input logic b, input logic [31:0] t,
                         input logic a, input logic [31:0] d);
        stall = s; jump = j; branch_taken = b; branch_target = t;
        u_if.imem_ack = a; u_if.imem_rdata = d;
    endtask

    // Reference model state: architectural view of the fetch stage.
    logic        m_idle;
    logic        m_busy;
    logic        m_squash;
    logic [31:0] m_pc;
    logic [31:0] m_redir;
    logic [31:0] m_instr;
    logic        m_valid;

    function automatic logic [31:0] align4(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    task automatic model_reset();
        m_idle = 1'b1; m_busy = 1'b0; m_squash = 1'b0;
        m_pc = 32'h0; m_redir = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic j, input logic b,
                              input logic [31:0] t, input logic a, input logic [31:0] d);
        if (m_idle) begin
            m_idle = 1'b0;
            m_busy = 1'b1;
        end else if (m_busy) begin
            if (m_squash) begin
                if (b) m_redir = align4(t);
                if (a) begin
                    m_squash = 1'b0;
                    m_pc = m_redir;
                end
            end else if (b) begin
                if (a) m_pc = align4(t);
                else begin
                    m_squash = 1'b1;
                    m_redir = align4(t);
                end
            end else if (a) begin
                m_instr = d;
                m_valid = 1'b1;
                m_pc = m_pc + 32'd4;
                m_busy = 1'b0;
            end
        end else begin
            if (b) begin
                m_pc = align4(t); m_valid = 1'b0; m_busy = 1'b1;
            end else if (j) begin
                m_pc = {m_pc[31:28], m_instr[25:0], 2'b00}; m_valid = 1'b0; m_busy = 1'b1;
            end else if (!s) begin
                m_valid = 1'b0; m_busy = 1'b1;
            end
        end
    endtask

    vec_t tbl[23];

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        //            st jp bt target        ack rdata          req addr          vld instr
        tbl[0]  = mk(0, 0, 1, 32'h0000_0500, 0, 32'h0,         0, 32'h0,         0, 32'h0);
        tbl[1]  = mk(1, 1, 0, 32'h0,         1, 32'h8C08_0004, 1, 32'h0,         0, 32'h0);
        tbl[2]  = mk(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h4,         1, 32'h8C08_0004);
        tbl[3]  = mk(1, 1, 0, 32'h0,         1, 32'h2008_0005, 1, 32'h4,         0, 32'h8C08_0004);
        tbl[4]  = mk(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h8,         1, 32'h2008_0005);
        tbl[5]  = mk(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h8,         1, 32'h2008_0005);
        tbl[6]  = mk(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h8,         1, 32'h2008_0005);
        tbl[7]  = mk(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h8,         1, 32'h2008_0005);
        tbl[8]  = mk(0, 0, 1, 32'h0000_0103, 0, 32'h0,         1, 32'h8,         0, 32'h2008_0005);
        tbl[9]  = mk(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h8,         0, 32'h2008_0005);
        tbl[10] = mk(0, 0, 0, 32'h0,         1, 32'hDEAD_BEEF, 1, 32'h8,         0, 32'h2008_0005);
        tbl[11] = mk(0, 0, 1, 32'h0040_0000, 1, 32'hBADC_0DE0, 1, 32'h100,       0, 32'h2008_0005);
        tbl[12] = mk(0, 0, 0, 32'h0,         1, 32'h0800_0010, 1, 32'h0040_0000, 0, 32'h2008_0005);
        tbl[13] = mk(0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0040_0004, 1, 32'h0800_0010);
        tbl[14] = mk(0, 0, 0, 32'h0,         1, 32'h1000_0001, 1, 32'h40,        0, 32'h0800_0010);
        tbl[15] = mk(0, 1, 1, 32'h0000_0200, 0, 32'h0,         0, 32'h44,        1, 32'h1000_0001);
        tbl[16] = mk(0, 0, 1, 32'h0000_1234, 0, 32'h0,         1, 32'h200,       0, 32'h1000_0001);
        tbl[17] = mk(0, 0, 1, 32'h0000_0300, 0, 32'h0,         1, 32'h200,       0, 32'h1000_0001);
        tbl[18] = mk(0, 0, 1, 32'hFFFF_FFFE, 0, 32'h0,         1, 32'h200,       0, 32'h1000_0001);
        tbl[19] = mk(0, 0, 0, 32'h0,         1, 32'h1111_1111, 1, 32'h200,       0, 32'h1000_0001);
        tbl[20] = mk(0, 0, 0, 32'h0,         1, 32'h0085_1020, 1, 32'hFFFF_FFFC, 0, 32'h1000_0001);
        tbl[21] = mk(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 32'h0085_1020);
        tbl[22] = mk(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0,         0, 32'h0085_1020);

        repeat (2) @(negedge clk);
        chk("reset_req", {31'h0, u_if.imem_req}, 32'h0);
        chk("reset_addr", u_if.imem_addr, 32'h0);
        chk("reset_valid", {31'h0, instr_valid}, 32'h0);
        chk("reset_instr", instr, 32'h0);
        chk("reset_pc_plus4", pc_plus4, 32'h0);
        rst_n = 1'b1;

        // Directed table: row i is observed in cycle i, its inputs applied during it.
        for (int i = 0; i < 23; i++) begin
            chk($sformatf("tbl%0d_req", i), {31'h0, u_if.imem_req}, {31'h0, tbl[i].e_req});
            chk($sformatf("tbl%0d_addr", i), u_if.imem_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_valid", i), {31'h0, instr_valid}, {31'h0, tbl[i].e_valid});
            chk($sformatf("tbl%0d_instr", i), instr, tbl[i].e_instr);
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_pc_plus4", i), pc_plus4, tbl[i].e_addr);
                chk($sformatf("tbl%0d_op", i), {26'h0, op}, {26'h0, tbl[i].e_instr[31:26]});
                chk($sformatf("tbl%0d_funct", i), {26'h0, funct}, {26'h0, tbl[i].e_instr[5:0]});
            end
            drive(tbl[i].stall, tbl[i].jump, tbl[i].bt, tbl[i].tgt, tbl[i].ack, tbl[i].rdata);
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Reset asserted while a request is outstanding.
        chk("pre_rst_req", {31'h0, u_if.imem_req}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_req", {31'h0, u_if.imem_req}, 32'h0);
        chk("midrst_addr", u_if.imem_addr, 32'h0);
        chk("midrst_instr", instr, 32'h0);
        chk("midrst_valid", {31'h0, instr_valid}, 32'h0);
        repeat (2) @(negedge clk);
        chk("midrst_hold_req", {31'h0, u_if.imem_req}, 32'h0);
        rst_n = 1'b1;
        chk("post_rst_c1_req", {31'h0, u_if.imem_req}, 32'h0);
        @(negedge clk);
        chk("post_rst_c2_req", {31'h0, u_if.imem_req}, 32'h1);
        chk("post_rst_c2_addr", u_if.imem_addr, 32'h0);

        // Randomized run against the reference model.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic        s, j, b, a;
            logic [31:0] t, d;
            chk("rnd_req", {31'h0, u_if.imem_req}, {31'h0, (m_busy && !m_idle)});
            chk("rnd_addr", u_if.imem_addr, m_pc);
            chk("rnd_valid", {31'h0, instr_valid}, {31'h0, m_valid});
            chk("rnd_instr", instr, m_instr);
            chk("rnd_op_funct", {20'h0, op, funct}, {20'h0, m_instr[31:26], m_instr[5:0]});
            if (m_valid) chk("rnd_pc_plus4", pc_plus4, m_pc);
            s = ($urandom_range(0, 2) == 0);
            j = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 7) == 0);
            t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                             : $urandom;
            a = m_busy && !m_idle && ($urandom_range(0, 1) == 0);
            d = ($urandom_range(0, 7) == 0) ? 32'h0BFF_FFFF : $urandom;
            drive(s, j, b, t, a, d);
            @(posedge clk);
            model_step(s, j, b, t, a, d);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mips_fetch_unit.md
# mips_fetch_unit

Instruction fetch stage of the MIPS processor, directly upstream of the main control decoder. It owns the program counter and issues word reads to instruction memory over a req/ack handshake. It holds the returned word in an instruction register whose opcode field drives the decoder's `op` input. It redirects the PC on taken branches from execute and on `jump` from the decoder.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `imem_req`  out  1  read request; held high until `imem_ack`.
- `imem_addr`  out  32  word address; equals PC, stable while `imem_req`=1.
- `imem_ack`  in  1  read data valid this cycle; completes the request.
- `imem_rdata`  in  32  instruction word, sampled when `imem_ack`=1.
- `stall`  in  1  hazard hold: keep the current instruction presented.
- `jump`  in  1  from decoder, for the presented instruction.
- `branch_taken`  in  1  from execute, for an older instruction.
- `branch_target`  in  32  branch PC; bits [1:0] ignored.
- `instr`  out  32  instruction register.
- `op`  out  6  `instr[31:26]`, to decoder `op`.
- `funct`  out  6  `instr[5:0]`, to ALU decoder.
- `instr_valid`  out  1  `instr` holds a live instruction.
- `pc_plus4`  out  32  PC+4 of the presented instruction; used for the `jal` link.

## Operation
- FSM states: IDLE, FETCH, VALID, DROP. Reset state is IDLE.
- IDLE:
  - `imem_req`=0.
  - Next cycle goes to FETCH unconditionally.
- FETCH:
  - `imem_req`=1, `imem_addr`=pc.
  - On `imem_ack` with no redirect: `instr`<=`imem_rdata`, `instr_valid`<=1, pc<=pc+4, go to VALID.
- VALID:
  - `imem_req`=0; `pc_plus4`=pc.
  - Redirect priority is `branch_taken` > `jump`. The branch is older, so it wins.
  - `branch_taken`: pc<={`branch_target`[31:2],2'b00}, `instr_valid`<=0, go to FETCH.
  - Else `jump`: pc<={pc[31:28],`instr`[25:0],2'b00}, `instr_valid`<=0, go to FETCH.
  - Else `stall`: hold all state.
  - Else the instruction is consumed: `instr_valid`<=0, go to FETCH.
- `branch_taken` in FETCH with `imem_ack` in the same cycle:
  - Discard `imem_rdata`; `instr` is unchanged and `instr_valid` stays 0.
  - pc<=branch target; stay in FETCH (new request next cycle).
- `branch_taken` in FETCH without `imem_ack`:
  - Save the target in `redir_pc`; go to DROP.
  - pc and `imem_addr` stay unchanged.
- DROP:
  - `imem_req`=1 at the old address.
  - On `imem_ack`: discard data, pc<=`redir_pc`, go to FETCH.
  - A further `branch_taken` in DROP overwrites `redir_pc` (the last one wins).
- `jump` and `stall` are ignored outside VALID. `branch_taken` is ignored in IDLE.
- Arithmetic: pc+4 is modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000). All targets have bits [1:0] forced to 0.

## Timing
- Reset values (asserted asynchronously, and held for as long as `rst_n`=0):
  - pc=`RESET_PC`, `redir_pc`=0, `instr`=0, `instr_valid`=0.
  - `imem_req`=0, `imem_addr`=`RESET_PC`, `pc_plus4`=`RESET_PC`, state IDLE.
- First `imem_req` is in the second cycle after `rst_n` rises.
- Fetch latency: `instr_valid` rises the cycle after `imem_ack`. With a zero-wait memory, one instruction is delivered every 2 cycles.
- `imem_req`, `imem_addr` and `pc_plus4` are decoded from registered state and pc; there are no input-to-output combinational paths.
- Reset mid-request: the request is abandoned and `imem_req` drops immediately. Memory must tolerate an abandoned request.
- `stall` held for N cycles holds `instr`, `op` and `pc_plus4` stable for N cycles.

## Structure
- Package `mips_fetch_pkg`: FSM state encoding (IDLE/FETCH/VALID/DROP), field constants OP_MSB=31, OP_LSB=26, JIDX_MSB=25, and a default reset-PC constant.
- One combinational sub-module, `fetch_pc_sel`:
  - Inputs: pc, `instr`, `branch_target`, `redir_pc`, and the select controls.
  - Output: next-pc.
  - Implements the redirect priority and the 2'b00 alignment.
- Top level: FSM, pc / `instr` / `redir_pc` registers, output decode.

## Test plan
- Reset then zero-wait memory returning 0x8C08_0004, `RESET_PC`=0:
  - `imem_addr`=0 in cycle 2; `instr_valid` in cycle 3.
  - `op`=6'b100011, `pc_plus4`=4; next `imem_addr`=4.
- `stall` held 3 cycles in VALID with `instr`=0x2008_0005 → `instr` and `pc_plus4` unchanged for 3 cycles; fetch at pc+4 follows.
- Presented 0x0800_0010 at pc 0x0040_0000 with `jump`=1 → next `imem_addr`=0x0000_0040, `instr_valid`=0 for that cycle.
- `branch_taken`=1, `branch_target`=0x0000_0103 in FETCH while ack is withheld 2 cycles:
  - `imem_addr` stays at the old PC until ack; that data is discarded.
  - Next request goes to 0x0000_0100.
- `jump` and `branch_taken` together in VALID → branch target wins.
- pc=0xFFFF_FFFC, fetch completes → `pc_plus4`=0; next `imem_addr`=0. Assert `rst_n`=0 during FETCH → `imem_req`=0 the same cycle and `imem_addr`=`RESET_PC`.
